// File: rtl/copro_vdot.sv
`default_nettype none
// ============================================================================
//  Module   : copro_vdot
//  Brief    : Dot-product coprocessor on the core req/rsp port. It streams
//             two operand vectors from shared memory over a read-only port
//             and returns one 32-bit result per accepted command.
//  Revision : 1.0 - initial release
// ============================================================================
module copro_vdot #(
  parameter int LEN_W     = 10,
  parameter int RESET_LEN = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        req_valid,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] c_OP_SETLEN = 7'h00;
  localparam logic [6:0] c_OP_DOT    = 7'h01;
  localparam logic [6:0] c_OP_DOTACC = 7'h02;
  localparam logic [6:0] c_OP_GETACC = 7'h03;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_ACC  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_acc;
  logic [31:0]        r_a;
  logic [31:0]        r_ptr_a;
  logic [31:0]        r_ptr_b;
  logic [31:0]        r_rd;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_is_stream;
  logic               w_last;
  logic [31:0]        w_prod;
  logic [31:0]        w_acc_nxt;

  assign w_is_stream = (req_funct7 == c_OP_DOT) || (req_funct7 == c_OP_DOTACC);
  assign w_last      = ((r_cnt + LEN_W'(1)) == r_len);
  // The low 32 bits of a signed product equal those of the unsigned product.
  assign w_prod      = r_a * mem_rdata;
  assign w_acc_nxt   = r_acc + w_prod;
  assign rsp_rd      = r_rd;

  // State register.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake / memory-port outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_en      = 1'b0;
    mem_addr    = 32'h0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Keep ready low while reset is asserted.
        req_ready = rstz;
        if (req_valid && rstz) begin
          w_accept = 1'b1;
          if (w_is_stream && (r_len != '0)) begin
            w_state_nxt = S_RD_A;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RD_A: begin
        mem_en      = 1'b1;
        mem_addr    = r_ptr_a;
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        mem_en      = 1'b1;
        mem_addr    = r_ptr_b;
        w_state_nxt = S_ACC;
      end
      S_ACC: begin
        w_state_nxt = w_last ? S_RESP : S_RD_A;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: command capture, operand latch, accumulate and result register.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_acc   <= 32'h0;
      r_a     <= 32'h0;
      r_ptr_a <= 32'h0;
      r_ptr_b <= 32'h0;
      r_rd    <= 32'h0;
      r_len   <= LEN_W'(RESET_LEN);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_ptr_a <= {req_rs1[31:2], 2'b00};
            r_ptr_b <= {req_rs2[31:2], 2'b00};
            case (req_funct7)
              c_OP_SETLEN: begin
                r_len <= req_rs1[LEN_W-1:0];
                r_rd  <= 32'(req_rs1[LEN_W-1:0]);
              end
              c_OP_DOT: begin
                r_acc <= 32'h0;
                r_rd  <= 32'h0;
              end
              c_OP_DOTACC: r_rd <= r_acc;
              c_OP_GETACC: r_rd <= r_acc;
              default:     r_rd <= 32'h0;
            endcase
          end
        end
        S_RD_B: begin
          r_a     <= mem_rdata;
          r_ptr_a <= r_ptr_a + 32'd4;
        end
        S_ACC: begin
          r_acc   <= w_acc_nxt;
          r_ptr_b <= r_ptr_b + 32'd4;
          r_cnt   <= r_cnt + LEN_W'(1);
          if (w_last) begin
            r_rd <= w_acc_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_copro_vdot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_copro_vdot
//  Brief    : Self-checking bench for copro_vdot with a memory model and a
//             behavioural dot-product reference.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_copro_vdot;

  localparam logic [6:0] OP_SETLEN = 7'h00;
  localparam logic [6:0] OP_DOT    = 7'h01;
  localparam logic [6:0] OP_DOTACC = 7'h02;
  localparam logic [6:0] OP_GETACC = 7'h03;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        req_valid = 1'b0;
  logic [6:0]  req_funct7 = 7'h0;
  logic [31:0] req_rs1 = 32'h0;
  logic [31:0] req_rs2 = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rd;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_acc = 32'h0;
  int          m_len = 1;

  // Memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_q [$];
  int          en_cnt = 0;

  copro_vdot #(.LEN_W(10), .RESET_LEN(1)) dut (
    .clk(clk), .rstz(rstz),
    .req_valid(req_valid), .req_funct7(req_funct7), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      addr_q.push_back(mem_addr);
      en_cnt = en_cnt + 1;
    end
  end

  // Reference dot product straight from the memory contents.
  function automatic logic [31:0] ref_dot(input logic [31:0] acc0, input logic [31:0] a,
                                          input logic [31:0] b, input int n);
    logic [31:0] acc = acc0;
    logic [31:0] pa = {a[31:2], 2'b00};
    logic [31:0] pb = {b[31:2], 2'b00};
    longint p;
    for (int i = 0; i < n; i++) begin
      logic [31:0] va = mem.exists(pa) ? mem[pa] : 32'h0;
      logic [31:0] vb = mem.exists(pb) ? mem[pb] : 32'h0;
      p   = longint'($signed(va)) * longint'($signed(vb));
      acc = acc + p[31:0];
      pa  = pa + 32'd4;
      pb  = pb + 32'd4;
    end
    return acc;
  endfunction

  // Issue one command from a negedge, wait for its response and complete it.
  task automatic do_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rd, output int lat);
    int cyc = 0;
    req_valid = 1'b1; req_funct7 = f; req_rs1 = a; req_rs2 = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_funct7 = 7'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
    lat = -1;
    rd  = 32'hx;
    while (cyc < 4000) begin
      cyc++;
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no rsp_valid within %0d cycles (funct7=%h)", cyc, f);
    end else begin
      rd = rsp_rd;
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    rstz = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || mem_en !== 1'b0 || rsp_rd !== 32'h0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b en=%b rd=%h addr=%h, expected 0 0 0 0 0",
               req_ready, rsp_valid, mem_en, rsp_rd, mem_addr);
    end
    rstz = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
    end
    m_acc = 0; m_len = 1;
    do_cmd(OP_GETACC, 0, 0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0 || lat !== 1) begin
      n_bad++; $display("FAIL reset_getacc: rd=%h lat=%0d expected 0 lat 1", rd, lat);
    end
  endtask

  task automatic test_dot_fixed();
    logic [31:0] rd; int lat;
    logic [31:0] exp_addr [8] = '{32'h400, 32'h500, 32'h404, 32'h504, 32'h408, 32'h508, 32'h40C, 32'h50C};
    for (int i = 0; i < 4; i++) begin
      mem[32'h400 + 4*i] = 32'(i + 1);
      mem[32'h500 + 4*i] = 32'(i + 5);
    end
    do_cmd(OP_SETLEN, 32'd4, 32'h0, rd, lat);
    m_len = 4;
    n_cmp++;
    if (rd !== 32'd4 || lat !== 1) begin
      n_bad++; $display("FAIL setlen4: rd=%h lat=%0d expected 4 lat 1", rd, lat);
    end
    addr_q.delete();
    do_cmd(OP_DOT, 32'h400, 32'h500, rd, lat);
    m_acc = ref_dot(32'h0, 32'h400, 32'h500, 4);
    n_cmp++;
    if (rd !== m_acc || rd !== 32'd70 || lat !== 13) begin
      n_bad++; $display("FAIL dot_fixed: rd=%0d lat=%0d expected 70 lat 13", rd, lat);
    end
    n_cmp++;
    if (addr_q.size() != 8) begin
      n_bad++; $display("FAIL dot_addr_count: got %0d reads expected 8", addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (addr_q[i] !== exp_addr[i]) begin
          n_bad++; $display("FAIL dot_addr_seq[%0d]: got %h expected %h", i, addr_q[i], exp_addr[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_dotacc();
    logic [31:0] rd; int lat;
    do_cmd(OP_DOTACC, 32'h400, 32'h500, rd, lat);
    m_acc = ref_dot(m_acc, 32'h400, 32'h500, 4);
    n_cmp++;
    if (rd !== m_acc || rd !== 32'd140) begin
      n_bad++; $display("FAIL dotacc: rd=%0d expected 140", rd);
    end
    do_cmd(OP_GETACC, 32'h0, 32'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'd140 || lat !== 1) begin
      n_bad++; $display("FAIL getacc_140: rd=%0d lat=%0d expected 140 lat 1", rd, lat);
    end
  endtask

  task automatic test_signed();
    logic [31:0] rd; int lat;
    do_cmd(OP_SETLEN, 32'd1, 32'h0, rd, lat);
    m_len = 1;
    mem[32'h600] = 32'hFFFF_FFFF; mem[32'h700] = 32'd3;
    // Unaligned bases must be forced down to word alignment.
    do_cmd(OP_DOT, 32'h603, 32'h702, rd, lat);
    n_cmp++;
    if (rd !== 32'hFFFF_FFFD || lat !== 4) begin
      n_bad++; $display("FAIL signed_neg: rd=%h lat=%0d expected FFFFFFFD lat 4", rd, lat);
    end
    mem[32'h600] = 32'h0001_0000; mem[32'h700] = 32'h0001_0000;
    do_cmd(OP_DOT, 32'h600, 32'h700, rd, lat);
    m_acc = 32'h0;
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++; $display("FAIL mul_wrap: rd=%h expected 0", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; int lat;
    logic [31:0] ra, rb, exp;
    logic [6:0]  op;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      do_cmd(OP_SETLEN, 32'(n) | 32'hABCD_0000 & 32'hFFFF_FC00, 32'h0, rd, lat);
      m_len = n;
      n_cmp++;
      if (rd !== 32'(n)) begin
        n_bad++; $display("FAIL rand_setlen: rd=%h expected %h", rd, 32'(n));
      end
      ra = (it == 0) ? 32'hFFFF_FFF6 : $urandom;
      rb = ra + 32'h0001_0000 + 32'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) begin
        mem[{ra[31:2], 2'b00} + 32'(4*i)] = $urandom;
        mem[{rb[31:2], 2'b00} + 32'(4*i)] = (i % 2 == 0) ? $urandom : -32'($urandom_range(0, 1000));
      end
      op = $urandom_range(0, 1) ? OP_DOT : OP_DOTACC;
      exp = ref_dot((op == OP_DOT) ? 32'h0 : m_acc, ra, rb, n);
      addr_q.delete();
      do_cmd(op, ra, rb, rd, lat);
      m_acc = exp;
      n_cmp++;
      if (rd !== exp || lat !== 3*n + 1) begin
        n_bad++; $display("FAIL rand_dot[%0d]: rd=%h lat=%0d expected %h lat %0d", it, rd, lat, exp, 3*n+1);
      end
      n_cmp++;
      if (addr_q.size() != 2*n || addr_q[2*n-2] !== {ra[31:2], 2'b00} + 32'(4*(n-1)) ||
          addr_q[2*n-1] !== {rb[31:2], 2'b00} + 32'(4*(n-1))) begin
        n_bad++; $display("FAIL rand_addr[%0d]: reads=%0d expected %0d", it, addr_q.size(), 2*n);
      end
    end
    do_cmd(7'h55, $urandom, $urandom, rd, lat);
    n_cmp++;
    if (rd !== 32'h0 || lat !== 1) begin
      n_bad++; $display("FAIL unknown_op: rd=%h lat=%0d expected 0 lat 1", rd, lat);
    end
    do_cmd(OP_GETACC, 32'h0, 32'h0, rd, lat);
    n_cmp++;
    if (rd !== m_acc) begin
      n_bad++; $display("FAIL rand_getacc: rd=%h expected %h", rd, m_acc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int cyc = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_funct7 = OP_GETACC; req_rs1 = 0; req_rs2 = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    held = rsp_rd;
    n_cmp++;
    if (held !== m_acc) begin
      n_bad++; $display("FAIL bp_value: rd=%h expected %h", held, m_acc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rd !== held || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d]: valid=%b rd=%h ready=%b expected 1 %h 0",
                          i, rsp_valid, rsp_rd, req_ready, held);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_len0();
    logic [31:0] rd; int lat; int en0;
    do_cmd(OP_SETLEN, 32'd0, 32'h0, rd, lat);
    m_len = 0;
    en0 = en_cnt;
    do_cmd(OP_DOTACC, 32'h400, 32'h500, rd, lat);
    n_cmp++;
    if (rd !== m_acc || lat !== 1) begin
      n_bad++; $display("FAIL len0_dotacc: rd=%h lat=%0d expected %h lat 1", rd, lat, m_acc);
    end
    do_cmd(OP_DOT, 32'h400, 32'h500, rd, lat);
    m_acc = 32'h0;
    n_cmp++;
    if (rd !== 32'h0 || lat !== 1 || en_cnt !== en0) begin
      n_bad++; $display("FAIL len0_dot: rd=%h lat=%0d mem_reads=%0d expected 0 lat 1 reads 0",
                        rd, lat, en_cnt - en0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; int seen = 0;
    do_cmd(OP_SETLEN, 32'd4, 32'h0, rd, lat);
    do_cmd(OP_DOTACC, 32'h400, 32'h500, rd, lat);
    m_acc = ref_dot(m_acc, 32'h400, 32'h500, 4);
    req_valid = 1'b1; req_funct7 = OP_DOT; req_rs1 = 32'h400; req_rs2 = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstz = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_async: en=%b ready=%b valid=%b expected 0 0 0",
                        mem_en, req_ready, rsp_valid);
    end
    @(negedge clk);
    rstz = 1'b1;
    m_acc = 32'h0; m_len = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL midreset_rsp: rsp_valid seen %0d cycles expected 0", seen);
    end
    @(negedge clk);
    do_cmd(OP_GETACC, 32'h0, 32'h0, rd, lat);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++; $display("FAIL midreset_getacc: rd=%h expected 0", rd);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dot_fixed();
    test_dotacc();
    test_signed();
    test_random();
    test_backpressure();
    test_len0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
